wb_retire_tracer: RTL and testbench
===================================

WB_RETIRE_TRACER -- requirements
Module: wb_retire_tracer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with port names clk and rst_n.
REQ-002 The block SHALL have these parameters:
- DEPTH, default 4, number of trace FIFO entries; a power of 2 and at least 2.
- PC_INIT, default 32'h200, reset value of trc_pc_o.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- wb_valid_i, in, 1, a non-bubble instruction retires this cycle.
- wb_pc_i, in, 32, PC of the retiring instruction.
- wb_insn_i, in, 32, instruction word.
- wb_we_i, in, 1, register-file write enable.
- wb_dst_i, in, 5, destination register index.
- wb_r_i, in, 32, write-back value.
- clr_i, in, 1, synchronous clear.
- trc_valid_o, out, 1, head entry is valid.
- trc_ready_i, in, 1, consumer accepts the head entry.
- trc_pc_o, out, 32, head PC.
- trc_insn_o, out, 32, head instruction word.
- trc_we_o, out, 1, head write enable.
- trc_rd_o, out, 5, head destination index.
- trc_wdata_o, out, 32, head write value.
- trc_order_o, out, 32, head retire sequence number.
- level_o, out, $clog2(DEPTH)+1, number of occupied entries.
- ovf_o, out, 1, sticky overflow flag.

Function
REQ-004 The block SHALL accept a retire (a push) on any rising edge where wb_valid_i=1, clr_i=0, and the FIFO is not full, or is full but popping in the same cycle.
REQ-005 Each pushed entry SHALL hold {pc, insn, we, rd, wdata, order}, with these rules:
- we = wb_we_i AND (wb_dst_i != 0).
- wdata = 0 when we = 0.
REQ-006 order SHALL come from an internal 32-bit counter that increments by 1 on each accepted push and wraps from 32'hFFFFFFFF to 0.
REQ-007 A pop SHALL occur on a rising edge where trc_valid_o=1 and trc_ready_i=1.
REQ-008 trc_valid_o SHALL equal (level_o != 0); no combinational path from wb_* inputs to trc_* outputs.
REQ-009 Latency: an entry pushed into an empty FIFO at edge N SHALL be visible on trc_* from edge N onward, with trc_valid_o=1 in the following cycle.
REQ-010 trc_* data SHALL stay stable while trc_valid_o=1 and trc_ready_i=0.
REQ-011 Entries SHALL be delivered in push order, and read and write pointers SHALL wrap modulo DEPTH.
REQ-012 Push and pop in the same cycle SHALL leave level_o unchanged, including at full and at a level of 1.
REQ-013 wb_valid_i=1 while the FIFO is full with no pop SHALL behave as follows:
- the entry is dropped;
- the order counter does not increment;
- ovf_o is set to 1.
REQ-014 ovf_o SHALL remain 1 until clr_i or reset.
REQ-015 clr_i=1 SHALL, on that edge, do all of the following, and clr_i has priority over a simultaneous push or pop:
- set level_o to 0;
- reset both pointers;
- clear ovf_o;
- set the order counter to 0;
- discard any simultaneous retire.
REQ-016 When empty, trc_* data outputs SHALL hold the last popped values and carry no meaning; consumers SHALL qualify them with trc_valid_o.

Reset
REQ-017 While rst_n=0 the block SHALL hold these values: trc_valid_o=0, level_o=0, ovf_o=0, order counter=0, trc_pc_o=PC_INIT, trc_insn_o=32'h13, trc_we_o=0, trc_rd_o=0, trc_wdata_o=0, trc_order_o=0.
REQ-018 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-019 The first push after reset deassertion SHALL carry order=0.

Verification
REQ-020 Single retire: wb_valid_i=1, pc=32'h200, insn=32'h00F57513, we=1, dst=10, r=32'h5, with trc_ready_i=1 -> next cycle trc_valid_o=1, pc=32'h200, rd=10, wdata=32'h5, order=0, we=1; level_o returns to 0 after the pop.
REQ-021 rd=x0 filtering: retire with wb_we_i=1, dst=0, r=32'hDEAD -> trc_we_o=0 and trc_wdata_o=0.
REQ-022 Overflow, DEPTH=4, trc_ready_i=0: 5 consecutive retires -> level_o=4 and ovf_o=1; pops then return order values 0,1,2,3; the next accepted retire carries order=4.
REQ-023 Full with simultaneous push and pop: level_o=4, then wb_valid_i=1 and trc_ready_i=1 for one cycle -> level_o=4, ovf_o=0, and the pushed entry is delivered fourth.
REQ-024 Clear with simultaneous retire: level_o=3, ovf_o=1, then clr_i=1 and wb_valid_i=1 -> level_o=0, ovf_o=0; the next retire carries order=0.
REQ-025 Wrap and reset: force the order counter to 32'hFFFFFFFF, then two retires -> orders 32'hFFFFFFFF and 0; assert rst_n=0 mid-stream -> trc_valid_o=0 asynchronously.

Source files
------------

// File: rtl/wb_retire_tracer.sv
// wb_retire_tracer: captures retiring write-back instructions into a small
// trace FIFO and presents the head entry on a valid/ready trace port.
// The head entry is kept in a dedicated register, so trc_* never depends
// combinationally on wb_* and still holds the last popped entry when empty.
module wb_retire_tracer #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_INIT = 32'h200
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid_i,
  input  logic [31:0]                wb_pc_i,
  input  logic [31:0]                wb_insn_i,
  input  logic                       wb_we_i,
  input  logic [4:0]                 wb_dst_i,
  input  logic [31:0]                wb_r_i,
  input  logic                       clr_i,
  output logic                       trc_valid_o,
  input  logic                       trc_ready_i,
  output logic [31:0]                trc_pc_o,
  output logic [31:0]                trc_insn_o,
  output logic                       trc_we_o,
  output logic [4:0]                 trc_rd_o,
  output logic [31:0]                trc_wdata_o,
  output logic [31:0]                trc_order_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] order;
  } ent_t;

  localparam ent_t HEAD_RST = '{pc: PC_INIT, insn: 32'h13, we: 1'b0,
                                rd: 5'd0, wdata: 32'd0, order: 32'd0};

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  ent_t          head_q, head_d;
  ent_t          new_ent;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   order_q, order_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, push;

  // Next-state: push/pop decode, storage write, head refresh, clear priority
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    order_d = order_q;
    ovf_d   = ovf_q;

    full   = (level_q == LW'(DEPTH));
    pop    = (level_q != '0) && trc_ready_i;
    push   = wb_valid_i && !clr_i && (!full || pop);
    rd_nxt = rd_q + AW'(1);

    new_ent.pc    = wb_pc_i;
    new_ent.insn  = wb_insn_i;
    new_ent.we    = wb_we_i && (wb_dst_i != 5'd0);
    new_ent.rd    = wb_dst_i;
    new_ent.wdata = new_ent.we ? wb_r_i : 32'd0;
    new_ent.order = order_q;

    if (clr_i) begin
      level_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      ovf_d   = 1'b0;
      order_d = '0;
    end else begin
      if (wb_valid_i && full && !pop) ovf_d = 1'b1;
      if (push) begin
        mem_d[wr_q] = new_ent;
        wr_d        = wr_q + AW'(1);
        order_d     = order_q + 32'd1;
      end
      if (pop) rd_d = rd_nxt;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      // Head tracks the oldest occupied entry; left alone once empty
      if (pop && level_q > LW'(1))          head_d = mem_q[rd_nxt];
      else if (push && (pop || level_q == '0)) head_d = new_ent;
    end
  end

  // State registers; reset discards every entry immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= HEAD_RST;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      order_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      order_q <= order_d;
      ovf_q   <= ovf_d;
    end
  end

  assign trc_valid_o = (level_q != '0);
  assign trc_pc_o    = head_q.pc;
  assign trc_insn_o  = head_q.insn;
  assign trc_we_o    = head_q.we;
  assign trc_rd_o    = head_q.rd;
  assign trc_wdata_o = head_q.wdata;
  assign trc_order_o = head_q.order;
  assign level_o     = level_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_wb_retire_tracer.sv
// Bench for wb_retire_tracer: a queue-based model of the trace FIFO checked
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_wb_retire_tracer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid_i = 1'b0, wb_we_i = 1'b0, clr_i = 1'b0, trc_ready_i = 1'b0;
  logic [31:0] wb_pc_i = '0, wb_insn_i = '0, wb_r_i = '0;
  logic [4:0]  wb_dst_i = '0;
  logic        trc_valid_o, trc_we_o, ovf_o;
  logic [31:0] trc_pc_o, trc_insn_o, trc_wdata_o, trc_order_o;
  logic [4:0]  trc_rd_o;
  logic [2:0]  level_o;

  wb_retire_tracer #(.DEPTH(DEPTH), .PC_INIT(32'h200)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .wb_insn_i(wb_insn_i), .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i),
    .wb_r_i(wb_r_i), .clr_i(clr_i), .trc_valid_o(trc_valid_o),
    .trc_ready_i(trc_ready_i), .trc_pc_o(trc_pc_o), .trc_insn_o(trc_insn_o),
    .trc_we_o(trc_we_o), .trc_rd_o(trc_rd_o), .trc_wdata_o(trc_wdata_o),
    .trc_order_o(trc_order_o), .level_o(level_o), .ovf_o(ovf_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, insn, wdata, order;
    logic        we;
    logic [4:0]  rd;
  } ent_t;

  int          n_cmp = 0, n_bad = 0;
  bit          cmp_en = 1'b0;
  ent_t        m_q[$];
  ent_t        m_show;
  logic [31:0] m_cnt;
  bit          m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_cnt = '0;
    m_ovf = 1'b0;
    m_show = '{pc: 32'h200, insn: 32'h13, wdata: 0, order: 0, we: 0, rd: 0};
  endtask

  // Model: one clock edge of the trace FIFO as a queue
  task automatic m_step();
    bit   full, pop;
    ent_t e;
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() > 0) && trc_ready_i;
    if (clr_i) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      if (wb_valid_i && full && !pop) m_ovf = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (wb_valid_i && (!full || pop)) begin
        e.pc = wb_pc_i; e.insn = wb_insn_i; e.rd = wb_dst_i;
        e.we = wb_we_i && (wb_dst_i != 0);
        e.wdata = e.we ? wb_r_i : 32'd0;
        e.order = m_cnt;
        m_q.push_back(e);
        m_cnt = m_cnt + 1;
      end
    end
    if (m_q.size() > 0) m_show = m_q[0];
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Compare every output against the model on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("valid", 32'(trc_valid_o), 32'(m_q.size() != 0));
        chk("level", 32'(level_o), 32'(m_q.size()));
        chk("ovf",   32'(ovf_o), 32'(m_ovf));
        chk("pc",    trc_pc_o, m_show.pc);
        chk("insn",  trc_insn_o, m_show.insn);
        chk("we",    32'(trc_we_o), 32'(m_show.we));
        chk("rd",    32'(trc_rd_o), 32'(m_show.rd));
        chk("wdata", trc_wdata_o, m_show.wdata);
        chk("order", trc_order_o, m_show.order);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                       input bit we, input logic [4:0] dst, input logic [31:0] r,
                       input bit rdy, input bit clr);
    wb_valid_i = v; wb_pc_i = pc; wb_insn_i = insn; wb_we_i = we;
    wb_dst_i = dst; wb_r_i = r; trc_ready_i = rdy; clr_i = clr;
  endtask

  task automatic idle(input bit rdy);
    drive(0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic ret(input logic [31:0] pc, input bit rdy);
    drive(1, pc, 32'h00000093 | (pc << 8), 1, pc[4:0], pc ^ 32'h5A5A, rdy, 0);
  endtask

  task automatic do_clr();
    drive(0, 0, 0, 0, 0, 0, 0, 1); cyc(); idle(0);
  endtask

  initial begin
    #12; cmp_en = 1'b1;
    // Reset values held while rst_n is low
    chk("rst_pc", trc_pc_o, 32'h200);
    chk("rst_insn", trc_insn_o, 32'h13);
    chk("rst_valid", 32'(trc_valid_o), 0);
    @(negedge clk); rst_n = 1'b1;

    // Single retire, consumer always ready
    drive(1, 32'h200, 32'h00F57513, 1, 5'd10, 32'h5, 1, 0); cyc();
    idle(1);
    chk("s_valid", 32'(trc_valid_o), 1);
    chk("s_pc", trc_pc_o, 32'h200);
    chk("s_rd", 32'(trc_rd_o), 10);
    chk("s_wdata", trc_wdata_o, 32'h5);
    chk("s_order", trc_order_o, 0);
    chk("s_we", 32'(trc_we_o), 1);
    cyc();
    chk("s_level0", 32'(level_o), 0);

    // Write to x0 is not a register write
    drive(1, 32'h204, 32'h00000013, 1, 5'd0, 32'hDEAD, 0, 0); cyc();
    idle(0);
    chk("x0_we", 32'(trc_we_o), 0);
    chk("x0_wdata", trc_wdata_o, 0);
    chk("x0_order", trc_order_o, 1);

    // Overflow: five retires into a depth-4 FIFO
    do_clr();
    for (int i = 0; i < 5; i++) begin ret(32'h300 + 4*i, 0); cyc(); end
    idle(0);
    chk("ovf_level", 32'(level_o), 4);
    chk("ovf_flag", 32'(ovf_o), 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_order", trc_order_o, 32'(i));
      idle(1); cyc();
    end
    idle(0);
    chk("ovf_empty", 32'(level_o), 0);
    ret(32'h400, 0); cyc(); idle(0);
    chk("ovf_next_order", trc_order_o, 4);
    chk("ovf_sticky", 32'(ovf_o), 1);

    // Full with simultaneous push and pop
    do_clr();
    for (int i = 0; i < 4; i++) begin ret(32'h500 + 4*i, 0); cyc(); end
    ret(32'h5F0, 1); cyc(); idle(0);
    chk("pp_level", 32'(level_o), 4);
    chk("pp_ovf", 32'(ovf_o), 0);
    chk("pp_head_order", trc_order_o, 1);
    for (int i = 0; i < 3; i++) begin idle(1); cyc(); end
    idle(0);
    chk("pp_fourth_pc", trc_pc_o, 32'h5F0);
    chk("pp_fourth_order", trc_order_o, 4);
    idle(1); cyc(); idle(0);

    // Clear beats a simultaneous retire
    for (int i = 0; i < 5; i++) begin ret(32'h600 + 4*i, 0); cyc(); end
    idle(1); cyc();
    chk("clr_pre_level", 32'(level_o), 3);
    chk("clr_pre_ovf", 32'(ovf_o), 1);
    drive(1, 32'h6F0, 32'h13, 1, 5'd3, 32'h1, 1, 1); cyc(); idle(0);
    chk("clr_level", 32'(level_o), 0);
    chk("clr_ovf", 32'(ovf_o), 0);
    ret(32'h700, 0); cyc(); idle(1);
    chk("clr_next_order", trc_order_o, 0);
    cyc();

    // Pseudo-random traffic checked by the model
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 40) == 0);
      cyc();
    end

    // Order counter wrap
    do_clr();
    force dut.order_q = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    #1 release dut.order_q;
    ret(32'h800, 0); cyc();
    ret(32'h804, 0); cyc(); idle(0);
    chk("wrap_first", trc_order_o, 32'hFFFFFFFF);
    idle(1); cyc(); idle(0);
    chk("wrap_second", trc_order_o, 0);

    // Asynchronous reset mid-stream
    ret(32'h808, 0); cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(trc_valid_o), 0);
    chk("arst_level", 32'(level_o), 0);
    chk("arst_pc", trc_pc_o, 32'h200);
    idle(0);
    @(negedge clk); rst_n = 1'b1;
    ret(32'h900, 0); cyc(); idle(0);
    chk("post_rst_order", trc_order_o, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
